// File: rtl/light_sensor.sv
// light_sensor: two-flop synchronizer, consecutive-sample debounce and edge pulses for a sensor DO pin.
// Define LIGHT_SENSOR_COUNT_EN to add event_count, a saturating count of light_rise events.
module light_sensor #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter bit DO_ACTIVE_HIGH  = 1'b1,
  parameter int COUNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               DO,
  output logic               light_detected,
  output logic               light_rise,
  output logic               light_fall
`ifdef LIGHT_SENSOR_COUNT_EN
  ,
  output logic [COUNT_W-1:0] event_count
`endif
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("light_sensor: DEBOUNCE_CYCLES must be within 1..255");
  end
  if (COUNT_W < 1) begin : g_bad_count_w
    $error("light_sensor: COUNT_W must be at least 1");
  end

  logic             s1;
  logic             s2;
  logic             sample;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             ld_next;
  logic             rise_next;
  logic             fall_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= DO;
      s2 <= s1;
    end
  end

  assign sample = DO_ACTIVE_HIGH ? s2 : ~s2;

  // Any sample agreeing with the current output restarts the run.
  always_comb begin
    ld_next  = light_detected;
    cnt_next = '0;
    if (sample != light_detected) begin
      if (db_cnt == CNT_LAST) begin
        ld_next = sample;
      end else begin
        cnt_next = db_cnt + 1'b1;
      end
    end
  end

  assign rise_next = ld_next & ~light_detected;
  assign fall_next = ~ld_next & light_detected;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt         <= '0;
      light_detected <= 1'b0;
      light_rise     <= 1'b0;
      light_fall     <= 1'b0;
    end else begin
      db_cnt         <= cnt_next;
      light_detected <= ld_next;
      light_rise     <= rise_next;
      light_fall     <= fall_next;
    end
  end

`ifdef LIGHT_SENSOR_COUNT_EN
  // Counts on the same edge that raises light_rise; holds at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      event_count <= '0;
    end else if (rise_next && (event_count != '1)) begin
      event_count <= event_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_light_sensor.sv
// Randomized bench for light_sensor: two instances (defaults, and inverted polarity with
// DEBOUNCE_CYCLES=3, COUNT_W=2) checked against a run-length reference model every cycle.
module tb_light_sensor;

  logic        clk = 1'b0;
  logic        rst;
  logic        DO = 1'b0;
  logic        ld0, r0, f0;
  logic        ld1, r1, f1;
`ifdef LIGHT_SENSOR_COUNT_EN
  logic [15:0] ec0;
  logic [1:0]  ec1;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b1;

  always #5 clk = ~clk;

  light_sensor u_dut0 (
    .clk(clk), .rst(rst), .DO(DO),
    .light_detected(ld0), .light_rise(r0), .light_fall(f0)
`ifdef LIGHT_SENSOR_COUNT_EN
    , .event_count(ec0)
`endif
  );

  light_sensor #(.DEBOUNCE_CYCLES(3), .DO_ACTIVE_HIGH(1'b0), .COUNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .DO(DO),
    .light_detected(ld1), .light_rise(r1), .light_fall(f1)
`ifdef LIGHT_SENSOR_COUNT_EN
    , .event_count(ec1)
`endif
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: synchronized samples since reset, output flips once the last
  // D samples all (after polarity) disagree with it.
  int   m_db [2] = '{2, 3};
  bit   m_pol[2] = '{1'b1, 1'b0};
  int   m_max[2] = '{65535, 3};
  logic m_ld [2] = '{1'b0, 1'b0};
  logic m_r  [2] = '{1'b0, 1'b0};
  logic m_f  [2] = '{1'b0, 1'b0};
  int   m_ec [2] = '{0, 0};
  logic d1 = 1'b0, d2 = 1'b0;
  logic sq[$];

  function automatic logic step_ld(input logic cur, input int d, input bit pol);
    logic s;
    if (sq.size() < d) return cur;
    for (int k = 0; k < d; k++) begin
      s = sq[sq.size() - 1 - k];
      if (!pol) s = ~s;
      if (s == cur) return cur;
    end
    return ~cur;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1 = 1'b0;
      d2 = 1'b0;
      sq.delete();
      for (int i = 0; i < 2; i++) begin
        m_ld[i] = 1'b0; m_r[i] = 1'b0; m_f[i] = 1'b0; m_ec[i] = 0;
      end
    end else begin
      logic nl;
      sq.push_back(d2);
      if (sq.size() > 8) void'(sq.pop_front());
      d2 = d1;
      d1 = DO;
      for (int i = 0; i < 2; i++) begin
        nl = step_ld(m_ld[i], m_db[i], m_pol[i]);
        m_r[i] = nl & ~m_ld[i];
        m_f[i] = ~nl & m_ld[i];
        if (m_r[i] && m_ec[i] < m_max[i]) m_ec[i]++;
        m_ld[i] = nl;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ld0", ld0, m_ld[0]);
      chk("rise0", r0, m_r[0]);
      chk("fall0", f0, m_f[0]);
      chk("ld1", ld1, m_ld[1]);
      chk("rise1", r1, m_r[1]);
      chk("fall1", f1, m_f[1]);
`ifdef LIGHT_SENSOR_COUNT_EN
      chk("ec0", ec0, m_ec[0]);
      chk("ec1", ec1, m_ec[1]);
`endif
    end
  end

  int cyc_idx = 0, hi0 = 0, rise0 = 0, fall0 = 0, fall1 = 0, rise_at = 0, fall_at = 0;

  task automatic clear_stats();
    hi0 = 0; rise0 = 0; fall0 = 0; fall1 = 0; rise_at = 0; fall_at = 0;
  endtask

  task automatic run(input logic d, input int n);
    repeat (n) begin
      @(negedge clk);
      DO = d;
      @(posedge clk);
      #1;
      cyc_idx++;
      if (ld0) hi0++;
      if (r0) begin rise0++; rise_at = cyc_idx; end
      if (f0) begin fall0++; fall_at = cyc_idx; end
      if (f1) fall1++;
    end
  endtask

  task automatic async_reset_check();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_ld0", ld0, 0);
    chk("arst_rise0", r0, 0);
    chk("arst_fall0", f0, 0);
    chk("arst_ld1", ld1, 0);
`ifdef LIGHT_SENSOR_COUNT_EN
    chk("arst_ec0", ec0, 0);
    chk("arst_ec1", ec1, 0);
`endif
  endtask

  initial begin
    int n;
    int t_hit;
    rst = 1'b0;
    repeat (4) begin
      #4 DO = ~DO;
      #1;
      chk("rst_ld0", ld0, 0);
      chk("rst_pulse0", r0 | f0, 0);
    end
    DO = 1'b0;
    rst = 1'b1;
    #1;

    // Clean step up at 50 ns: visible at the 85 ns edge, rise for one cycle.
    run(1'b0, 2);
    run(1'b1, 1);
    n = 1;
    while (ld0 !== 1'b1 && n < 20) begin run(1'b1, 1); n++; end
    t_hit = int'($time) - 1;
    chk("step_lat", n, 4);
    chk("step_time", t_hit, 85);
    chk("step_rise", r0, 1);
    run(1'b1, 1);
    chk("step_rise_1cyc", r0, 0);

    // 40 ns pulse.
    run(1'b0, 10);
    clear_stats();
    run(1'b1, 4);
    run(1'b0, 12);
    chk("pulse_hi", hi0, 4);
    chk("pulse_rise", rise0, 1);
    chk("pulse_fall", fall0, 1);
    chk("pulse_gap", fall_at - rise_at, 4);

    // Glitch rejection: 1-cycle high on D=2, 2-cycle dark on D=3, 1-cycle dip in a high.
    clear_stats();
    run(1'b1, 1);
    run(1'b0, 10);
    chk("glitch_hi", hi0, 0);
    chk("glitch1_fall", fall1, 0);
    clear_stats();
    run(1'b1, 2);
    run(1'b0, 10);
    chk("glitch_d3", fall1, 0);
    run(1'b1, 10);
    clear_stats();
    run(1'b0, 1);
    run(1'b1, 10);
    chk("dip_fall", fall0, 0);
    chk("dip_ld", ld0, 1);

    // Toggling every cycle holds the output in either state.
    clear_stats();
    for (int i = 0; i < 30; i++) run(1'(i % 2), 1);
    chk("tog_hold_hi", fall0, 0);
    run(1'b0, 10);
    clear_stats();
    for (int i = 0; i < 30; i++) run(1'(i % 2 == 0), 1);
    chk("tog_hold_lo", rise0, 0);

    // Inverted polarity, D=3: DO going high clears light after 5 edges.
    run(1'b0, 12);
    chk("pol_light", ld1, 1);
    run(1'b1, 1);
    n = 1;
    while (ld1 !== 1'b0 && n < 20) begin run(1'b1, 1); n++; end
    chk("pol_lat", n, 5);

    // Randomized runs and per-cycle noise.
    for (int i = 0; i < 250; i++) run(1'($urandom_range(0, 1)), $urandom_range(1, 7));
    for (int i = 0; i < 300; i++) run(1'($urandom_range(0, 1)), 1);

    // Asynchronous reset mid-count, then full-latency recovery with DO held high.
    run(1'b1, 10);
    async_reset_check();
    run(1'b1, 3);
    @(negedge clk) rst = 1'b1;
    n = 0;
    while (ld0 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("rearm_lat", n, 4);

`ifdef LIGHT_SENSOR_COUNT_EN
    // Saturating count on the 2-bit instance: light is DO=0 there.
    for (int k = 1; k <= 5; k++) begin
      run(1'b0, 8);
      run(1'b1, 8);
      chk("ec_sat", ec1, (k < 3) ? k : 3);
    end
    run(1'b0, 6);
    async_reset_check();
    @(negedge clk) rst = 1'b1;
    run(1'b1, 6);
`endif

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
